sa_2d_os_array: RTL

SA_2D_OS_ARRAY -- requirements
Module: sa_2d_os_array

---
 rtl/sa_2d_os_array.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/sa_2d_os_array.sv
// sa_2d_os_array
//   Output-stationary ROWS x COLS multiply-accumulate grid.
//   Each PE(r,c) adds a*b to its own accumulator every cycle, forwards
//   its a operand to the right and its b operand downward through one
//   register each. Operand lanes are skewed internally (A lane r by r
//   cycles, B lane c by c cycles), so the caller presents unskewed beats.
//
//   Build option: define SA_SIGNED_EN for two's-complement operands with
//   sign-extended products; otherwise operands are unsigned and products
//   are zero-extended.
//
// Ports
//   CLK       clock, all state updates on the rising edge
//   RST       synchronous active-high reset
//   START     start request, honoured only in IDLE
//   K_LEN     number of operand beats, captured with START
//   A_IN      row operands, lane r at [(r+1)*WIDTH-1 : r*WIDTH]
//   B_IN      column operands, lane c at [(c+1)*WIDTH-1 : c*WIDTH]
//   IN_VALID  A_IN/B_IN beat valid
//   IN_READY  high only while loading beats
//   BUSY      high in every state except IDLE
//   DONE      one-cycle pulse, Y is final
//   Y         PE(r,c) accumulator at word r*COLS+c, LSB-first
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for START; Y holds the previous job's results
// LOAD  | accepting K_LEN beats on IN_VALID & IN_READY
// FLUSH | draining the skew chains and grid, ROWS+COLS-1 cycles
// DONE  | one cycle, DONE=1, then back to IDLE

module sa_2d_os_array #(
   parameter int WIDTH = 8,
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int KW    = 8
) (
   input  logic                                    CLK,
   input  logic                                    RST,
   input  logic                                    START,
   input  logic [KW-1:0]                           K_LEN,
   input  logic [WIDTH*ROWS-1:0]                   A_IN,
   input  logic [WIDTH*COLS-1:0]                   B_IN,
   input  logic                                    IN_VALID,
   output logic                                    IN_READY,
   output logic                                    BUSY,
   output logic                                    DONE,
   output logic [(2*WIDTH+KW)*ROWS*COLS-1:0]       Y
);

   localparam int ACCW = 2*WIDTH + KW;
   localparam int FW   = $clog2(ROWS+COLS) + 1;
   localparam logic [FW-1:0] FLUSH_LOAD = FW'(ROWS+COLS-2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [KW-1:0]   k_cnt;
   logic [FW-1:0]   flush_cnt;
   logic            accept;
   logic            clear_acc;

   function automatic logic [ACCW-1:0] mul_ext(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
`ifdef SA_SIGNED_EN
      logic signed [2*WIDTH-1:0] p;
      p = $signed(a) * $signed(b);
      return {{KW{p[2*WIDTH-1]}}, p};
`else
      logic [2*WIDTH-1:0] p;
      p = a * b;
      return {{KW{1'b0}}, p};
`endif
   endfunction

   assign IN_READY  = (state_q == S_LOAD);
   assign BUSY      = (state_q != S_IDLE);
   assign DONE      = (state_q == S_DONE);
   assign accept    = IN_VALID & IN_READY;
   assign clear_acc = (state_q == S_IDLE) & START;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (START) state_d = (K_LEN == '0) ? S_FLUSH : S_LOAD;
         S_LOAD:  if (accept && (k_cnt == KW'(1))) state_d = S_FLUSH;
         S_FLUSH: if (flush_cnt == '0) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Beat down-counter and flush timer; the flush timer is loaded on the
   // edge that enters FLUSH and reaches terminal count on its last cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         k_cnt     <= '0;
         flush_cnt <= '0;
      end else begin
         if (clear_acc)   k_cnt <= K_LEN;
         else if (accept) k_cnt <= k_cnt - KW'(1);

         if ((state_d == S_FLUSH) && (state_q != S_FLUSH)) flush_cnt <= FLUSH_LOAD;
         else if (state_q == S_FLUSH)                       flush_cnt <= flush_cnt - FW'(1);
      end
   end

   logic [WIDTH-1:0] a_skew [ROWS];
   logic [WIDTH-1:0] b_skew [COLS];
   logic [WIDTH-1:0] a_fwd  [ROWS][COLS];
   logic [WIDTH-1:0] b_fwd  [ROWS][COLS];

   // Cycles without an accepted beat push zeros, so bubbles add nothing.
   for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
      logic [WIDTH-1:0] a_lane;
      assign a_lane = accept ? A_IN[r*WIDTH +: WIDTH] : '0;
      if (r == 0) begin : g_direct
         assign a_skew[r] = a_lane;
      end else begin : g_chain
         logic [WIDTH-1:0] dly [r];
         always_ff @(posedge CLK) begin
            if (RST) begin
               for (int i = 0; i < r; i++) dly[i] <= '0;
            end else begin
               dly[0] <= a_lane;
               for (int i = 1; i < r; i++) dly[i] <= dly[i-1];
            end
         end
         assign a_skew[r] = dly[r-1];
      end
   end

   for (genvar c = 0; c < COLS; c++) begin : g_b_skew
      logic [WIDTH-1:0] b_lane;
      assign b_lane = accept ? B_IN[c*WIDTH +: WIDTH] : '0;
      if (c == 0) begin : g_direct
         assign b_skew[c] = b_lane;
      end else begin : g_chain
         logic [WIDTH-1:0] dly [c];
         always_ff @(posedge CLK) begin
            if (RST) begin
               for (int i = 0; i < c; i++) dly[i] <= '0;
            end else begin
               dly[0] <= b_lane;
               for (int i = 1; i < c; i++) dly[i] <= dly[i-1];
            end
         end
         assign b_skew[c] = dly[c-1];
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_pe
         logic [WIDTH-1:0] a_in, b_in, a_q, b_q;
         logic [ACCW-1:0]  acc_q;

         if (c == 0) begin : g_a_edge
            assign a_in = a_skew[r];
         end else begin : g_a_int
            assign a_in = a_fwd[r][c-1];
         end

         if (r == 0) begin : g_b_edge
            assign b_in = b_skew[c];
         end else begin : g_b_int
            assign b_in = b_fwd[r-1][c];
         end

         always_ff @(posedge CLK) begin
            if (RST) begin
               a_q   <= '0;
               b_q   <= '0;
               acc_q <= '0;
            end else begin
               a_q   <= a_in;
               b_q   <= b_in;
               acc_q <= clear_acc ? '0 : acc_q + mul_ext(a_in, b_in);
            end
         end

         assign a_fwd[r][c] = a_q;
         assign b_fwd[r][c] = b_q;
         assign Y[(r*COLS+c)*ACCW +: ACCW] = acc_q;
      end
   end

endmodule
